// File: rtl/data_register_bank.sv
// rtl/data_register_bank.sv - snapshot-coherent register bank with clear-on-read status for an I2C reader
module data_register_bank #(
    parameter int           NUM_CH   = 3,
    parameter int           DATA_W   = 8,
    parameter int           ADDR_W   = 4,
    parameter logic [7:0]   ID_VALUE = 8'hAA
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic                       txn_start,
    input  logic [ADDR_W-1:0]          txn_addr,
    input  logic                       rd_ack,
    output logic [DATA_W-1:0]          data_out,
    output logic [ADDR_W-1:0]          rd_ptr
);

    localparam logic [DATA_W-1:0] ID_WORD     = DATA_W'(ID_VALUE);
    localparam logic [ADDR_W-1:0] ID_ADDR     = '0;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_CH + 1);

    logic [DATA_W-1:0] live       [NUM_CH];
    logic [DATA_W-1:0] shadow     [NUM_CH];
    logic [NUM_CH-1:0] new_flag;
    logic [NUM_CH-1:0] shadow_status;

    logic [DATA_W-1:0] shadow_nx  [NUM_CH];
    logic [NUM_CH-1:0] status_nx;
    logic [ADDR_W-1:0] ptr_nx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] status_word;
    logic              status_clear;

    // Next snapshot and pointer: txn_start takes the pre-edge live values and overrides any ack
    always_comb begin
        status_nx = shadow_status;
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_nx[i] = shadow[i];
        end
        if (txn_start) begin
            status_nx = new_flag;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_nx[i] = live[i];
            end
        end

        ptr_nx = rd_ptr;
        if (txn_start) begin
            ptr_nx = txn_addr;
        end else if (rd_ack) begin
            ptr_nx = (rd_ptr >= LAST_ADDR) ? '0 : rd_ptr + ADDR_W'(1);
        end

        status_clear = rd_ack && !txn_start && (rd_ptr == STATUS_ADDR);
    end

    // Map lookup for the byte that data_out will present after this edge
    always_comb begin
        status_word               = '0;
        status_word[NUM_CH-1:0]   = status_nx;
        rd_word                   = '0;
        if (ptr_nx == ID_ADDR) begin
            rd_word = ID_WORD;
        end else if (ptr_nx == STATUS_ADDR) begin
            rd_word = status_word;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ptr_nx == ADDR_W'(i + 2)) begin
                    rd_word = shadow_nx[i];
                end
            end
        end
    end

    // State update: live capture, snapshot, sticky flags (set beats clear), pointer and read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            new_flag      <= '0;
            shadow_status <= '0;
            rd_ptr        <= '0;
            data_out      <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i]) begin
                    live[i] <= ch_data[i*DATA_W +: DATA_W];
                end
                shadow[i] <= shadow_nx[i];
            end
            new_flag      <= (new_flag & ~(status_clear ? shadow_status : '0)) | ch_valid;
            shadow_status <= status_nx;
            rd_ptr        <= ptr_nx;
            data_out      <= rd_word;
        end
    end

endmodule

// File: tb/tb_data_register_bank.sv
// tb/tb_data_register_bank.sv - randomized bench for data_register_bank against a behavioural model
module tb_data_register_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] ch_data;
    logic [2:0]  ch_valid;
    logic        txn_start;
    logic [3:0]  txn_addr;
    logic        rd_ack;
    logic [7:0]  data_out;
    logic [3:0]  rd_ptr;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 1'b0;

    // behavioural model state
    logic [7:0] m_live   [3];
    logic [7:0] m_shadow [3];
    logic [2:0] m_flag;
    logic [2:0] m_sflag;
    int         m_ptr;
    logic [7:0] m_dout;

    data_register_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .txn_start (txn_start),
        .txn_addr  (txn_addr),
        .rd_ack    (rd_ack),
        .data_out  (data_out),
        .rd_ptr    (rd_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_map(input int a);
        if (a == 0)                return 8'hAA;
        else if (a == 1)           return {5'b0, m_sflag};
        else if (a >= 2 && a <= 4) return m_shadow[a-2];
        else                       return 8'h00;
    endfunction

    // Model: one clock edge computed from the register-map rules
    task automatic model_edge();
        logic [7:0] old_live [3];
        logic [2:0] old_flag;
        int         old_ptr;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_live[i] = 8'h00; m_shadow[i] = 8'h00;
            end
            m_flag = 3'b0; m_sflag = 3'b0; m_ptr = 0; m_dout = 8'h00;
            return;
        end
        old_live = m_live;
        old_flag = m_flag;
        old_ptr  = m_ptr;
        if (txn_start) begin
            m_shadow = old_live;
            m_sflag  = old_flag;
            m_ptr    = txn_addr;
        end else if (rd_ack) begin
            m_ptr = (old_ptr >= 4) ? 0 : old_ptr + 1;
            if (old_ptr == 1) m_flag = m_flag & ~m_sflag;
        end
        m_flag = m_flag | ch_valid;
        for (int i = 0; i < 3; i++)
            if (ch_valid[i]) m_live[i] = ch_data[i*8 +: 8];
        m_dout = m_map(m_ptr);
    endtask

    task automatic step(input logic rn, input logic [2:0] v, input logic [23:0] d,
                        input logic st, input logic [3:0] a, input logic ack);
        rst_n = rn; ch_valid = v; ch_data = d; txn_start = st; txn_addr = a; rd_ack = ack;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_en = 1'b1;
    endtask

    // Compare process: outputs checked against the model on every cycle
    always @(negedge clk) begin
        if (check_en) begin
            check("data_out", data_out, m_dout);
            check("rd_ptr",   rd_ptr,   m_ptr);
        end
    end

    initial begin
        rst_n = 1'b0; ch_valid = '0; ch_data = '0; txn_start = 1'b0; txn_addr = '0; rd_ack = 1'b0;
        @(negedge clk);

        // 1: reset, idle, live capture invisible
        step(0, 3'b000, 24'h0, 0, 0, 0);              check("t1_reset_dout", data_out, 8'h00);
        step(1, 3'b000, 24'h0, 0, 0, 0);              check("t1_idle_dout", data_out, 8'hAA);
                                                      check("t1_idle_ptr", rd_ptr, 0);
        step(1, 3'b111, 24'h332211, 0, 0, 0);         check("t1_no_snap", data_out, 8'hAA);

        // 2: sequential read through the map and wrap
        step(1, 3'b000, 24'h0, 1, 0, 0);              check("t2_id", data_out, 8'hAA);
        step(1, 3'b000, 24'h0, 0, 0, 1);              check("t2_status", data_out, 8'h07);
        step(1, 3'b000, 24'h0, 0, 0, 1);              check("t2_ch0", data_out, 8'h11);
        step(1, 3'b000, 24'h0, 0, 0, 1);              check("t2_ch1", data_out, 8'h22);
        step(1, 3'b000, 24'h0, 0, 0, 1);              check("t2_ch2", data_out, 8'h33);
        step(1, 3'b000, 24'h0, 0, 0, 1);              check("t2_wrap", data_out, 8'hAA);

        // 3: coherency
        step(1, 3'b001, 24'h00005A, 1, 2, 0);         check("t3_old", data_out, 8'h11);
        step(1, 3'b000, 24'h0, 1, 2, 0);              check("t3_new", data_out, 8'h5A);

        // 4: status clear-on-read with set priority
        step(1, 3'b100, 24'h440000, 0, 0, 0);
        step(1, 3'b000, 24'h0, 1, 1, 0);              check("t4_status", data_out, 8'h05);
        step(1, 3'b001, 24'h000066, 0, 0, 1);         check("t4_ack", data_out, 8'h5A);
        step(1, 3'b000, 24'h0, 1, 1, 0);              check("t4_cleared", data_out, 8'h01);

        // 5: priority and out-of-range address
        step(1, 3'b000, 24'h0, 1, 9, 1);              check("t5_ptr", rd_ptr, 9);
                                                      check("t5_dout", data_out, 8'h00);
        step(1, 3'b000, 24'h0, 0, 0, 1);              check("t5_wrap_ptr", rd_ptr, 0);
                                                      check("t5_wrap_dout", data_out, 8'hAA);

        // 6: reset mid-read
        step(1, 3'b000, 24'h0, 1, 3, 0);              check("t6_ch1", data_out, 8'h22);
        step(0, 3'b000, 24'h0, 0, 0, 0);              check("t6_rst_dout", data_out, 8'h00);
                                                      check("t6_rst_ptr", rd_ptr, 0);
        step(1, 3'b000, 24'h0, 0, 0, 1);              check("t6_ack_after_rst", data_out, 8'h07 & 8'h00);
        step(1, 3'b000, 24'h0, 1, 2, 0);              check("t6_ch0_zero", data_out, 8'h00);
        step(1, 3'b000, 24'h0, 1, 1, 0);              check("t6_flags_zero", data_out, 8'h00);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) != 0),
                 3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                 24'($urandom),
                 ($urandom_range(0, 5) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1));
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_register_bank.md
Name: data_register_bank

Overview:
- Parametrised, clocked successor to the I2C-facing holding-register mux.
- Captures NUM_CH peripheral samples (ADC channels) on per-channel valid strobes into live registers.
- Presents them to the I2C controller through a snapshot and auto-increment read pointer, so multi-byte reads are coherent.
- Adds a sticky new-data STATUS register, cleared when read.

Parameters:
- NUM_CH, 3, number of sample channels; legal range 1 to DATA_W, with NUM_CH+2 <= 2^ADDR_W.
- DATA_W, 8, width of each register and of data_out.
- ADDR_W, 4, register address width.
- ID_VALUE, 8'hAA, constant returned at address 0; truncated or zero-extended to DATA_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ch_data  input  NUM_CH*DATA_W  channel samples; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_valid  input  NUM_CH  per-channel single-cycle sample strobe.
- txn_start  input  1  I2C controller pulse: new read transaction at txn_addr.
- txn_addr  input  ADDR_W  start register address, sampled with txn_start.
- rd_ack  input  1  pulse: current data_out byte consumed; advance pointer.
- data_out  output  DATA_W  registered read data.
- rd_ptr  output  ADDR_W  current read pointer (debug/verification).

Behaviour:
- Clock and reset: one clock is clk. Reset is synchronous and active-low on rst_n: when rst_n=0 at a rising edge, all state is cleared.
  - Reset values: live[i]=0, shadow[i]=0, shadow_status=0, new_flag=0, rd_ptr=0, data_out=0.
- Address map:
  - 0 = ID_VALUE.
  - 1 = STATUS: bit i = new_flag[i]; upper bits 0.
  - 2+i = channel i sample, for i in 0..NUM_CH-1.
  - Any address >= NUM_CH+2 reads 0.
- Live capture: ch_valid[i]=1 at an edge sets live[i] <= ch_data slice i and new_flag[i] <= 1. Channels are independent; any combination of channels may be valid in the same cycle.
- Snapshot: txn_start=1 at an edge copies all live[i] into shadow[i] and new_flag into shadow_status.
  - The copy uses register values before that edge: a ch_valid in the same cycle is NOT in the snapshot, but it does update live and new_flag.
- Pointer:
  - txn_start: rd_ptr <= txn_addr.
  - Else rd_ack: rd_ptr <= rd_ptr+1; wraps to 0 when rd_ptr >= NUM_CH+1, which includes out-of-range addresses.
  - txn_start and rd_ack in the same cycle: txn_start wins and rd_ack is ignored.
- data_out:
  - Registered. At every edge (not in reset) it loads the map entry for the next rd_ptr, using the next shadow contents.
  - Latency is 1 cycle from txn_start or rd_ack to the new byte. The first byte of a transaction is valid the cycle after txn_start.
  - With no txn_start, reads come from the shadow, which never changes between transactions: live updates are invisible until the next txn_start.
  - Before the first txn_start, the shadow holds reset zeros; address 0 still returns ID_VALUE.
- STATUS clear-on-read:
  - rd_ack with rd_ptr==1 (txn_start not asserted) clears the new_flag bits that are set in shadow_status.
  - If ch_valid[i] is asserted in the same cycle, set wins: new_flag[i] stays 1.
  - Bits that were 0 in the snapshot are not cleared.
  - A transaction that never acks address 1 clears nothing.
- Reset mid-transaction: everything returns to reset values; a following rd_ack without txn_start reads from pointer 0.
- No write path. A txn_addr outside the map is accepted; it reads 0 until the pointer wraps.

Test Plan:
1. Reset, then one idle cycle: data_out=0x00 during reset → 0xAA after release with rd_ptr=0. Set ch_valid=3'b111 with ch_data = {0x33,0x22,0x11}; no txn_start → data_out stays 0xAA.
2. After test 1: txn_start with txn_addr=0, then 4 rd_ack pulses → data_out sequence 0xAA, 0x07, 0x11, 0x22, 0x33. Then one more rd_ack → wraps to 0xAA.
3. Coherency: txn_start addr=2 while ch_valid[0]=1 with data 0x5A (live ch0 was 0x11) → data_out=0x11. The next transaction at addr=2 → 0x5A.
4. STATUS clear: flags=3'b101; txn_start addr=1; rd_ack at the same edge as ch_valid[0] → flags become 3'b001. A new transaction at addr=1 → data_out=0x01.
5. Priority and range: txn_start addr=9 together with rd_ack → rd_ptr=9, data_out=0x00. One rd_ack → rd_ptr=0, data_out=0xAA.
6. rst_n=0 for one edge mid-read at rd_ptr=3 → data_out=0, rd_ptr=0, flags=0. A subsequent txn_start addr=2 → 0x00.
